fetch_ctrl: RTL

Fetch sequencer for the program counter and instruction memory. It requests each instruction, captures it into the instruction register and holds it for decode. Once decode accepts the instruction, it advances the PC with an increment or a load (branch, jump, exception vector). It sits between the `pc` register, the instruction memory port and the decode stage, and is the only driver of the PC load/increment controls.

---
 rtl/fetch_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer driving instruction memory requests, the instruction
// register load and the PC load/increment controls for one instruction at a time.
`default_nettype none

module fetch_ctrl #(
    parameter int                   DATAWIDTH  = 32,
    parameter logic [DATAWIDTH-1:0] EXC_VECTOR = 32'h0000_0080,
    parameter int                   TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 imem_ready,
    input  logic                 stall,
    input  logic                 br_taken,
    input  logic [DATAWIDTH-1:0] br_target,
    input  logic                 jmp,
    input  logic [DATAWIDTH-1:0] jmp_target,
    input  logic                 exc,
    input  logic                 halt,
    output logic                 imem_req,
    output logic                 ir_ld,
    output logic                 fetch_valid,
    output logic                 pc_ld,
    output logic                 pc_incr,
    output logic [DATAWIDTH-1:0] pc_in,
    output logic                 fetch_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_HALTED = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_UPDATE = 3'd3,
        S_FLUSH  = 3'd4
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   upd_ld;
    logic                   upd_incr;
    logic [DATAWIDTH-1:0]   upd_val;
    logic [DATAWIDTH-1:0]   pc_in_q;
    logic                   pc_ld_q;
    logic                   pc_incr_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_inc;
    logic                   err_q;
    logic                   wait_cycle;

    // Next state plus the PC action that is registered on the edge entering UPDATE.
    always_comb begin
        state_d  = state_q;
        upd_ld   = 1'b0;
        upd_incr = 1'b0;
        upd_val  = pc_in_q;
        case (state_q)
            S_HALTED: begin
                if (exc) begin
                    state_d = S_UPDATE;
                    upd_ld  = 1'b1;
                    upd_val = EXC_VECTOR;
                end else if (!halt) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (exc) begin
                    state_d = S_UPDATE;
                    upd_ld  = 1'b1;
                    upd_val = EXC_VECTOR;
                end else if (imem_ready) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (exc) begin
                    state_d = S_UPDATE;
                    upd_ld  = 1'b1;
                    upd_val = EXC_VECTOR;
                end else if (!stall) begin
                    state_d = S_UPDATE;
                    if (jmp) begin
                        upd_ld  = 1'b1;
                        upd_val = jmp_target;
                    end else if (br_taken) begin
                        upd_ld  = 1'b1;
                        upd_val = br_target;
                    end else begin
                        upd_incr = 1'b1;
                    end
                end
            end
            S_UPDATE: begin
                if (exc) begin
                    state_d = S_UPDATE;
                    upd_ld  = 1'b1;
                    upd_val = EXC_VECTOR;
                end else if (halt) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_FLUSH: begin
                if (imem_ready) begin
                    state_d = S_UPDATE;
                    upd_ld  = 1'b1;
                    upd_val = EXC_VECTOR;
                end
            end
            default: state_d = S_HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HALTED;
            pc_ld_q   <= 1'b0;
            pc_incr_q <= 1'b0;
            pc_in_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_ld_q   <= upd_ld;
            pc_incr_q <= upd_incr;
            pc_in_q   <= upd_val;
        end
    end

    // Timeout counter: restarts on each FETCH entry, saturates, and latches a sticky error.
    assign wait_cycle = (state_q == S_FETCH) && !imem_ready;
    assign cnt_inc    = (cnt_q == TMAX) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if ((state_q != S_FETCH) && (state_d == S_FETCH)) begin
                cnt_q <= '0;
            end else if (wait_cycle) begin
                cnt_q <= cnt_inc;
            end
            if (wait_cycle && (cnt_inc == TMAX)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign imem_req    = (state_q == S_FETCH);
    assign fetch_valid = (state_q == S_ISSUE);
    assign ir_ld       = (state_q == S_FETCH) && imem_ready && !exc;
    assign pc_ld       = pc_ld_q;
    assign pc_incr     = pc_incr_q;
    assign pc_in       = pc_in_q;
    assign fetch_err   = err_q;

endmodule

`default_nettype wire
